pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
//   Central freeze/flush sequencer for the 5-stage ARM pipeline with cache. Combines the
//   cache/SRAM ready handshake, the hazard-unit stall request and the EXE-stage taken branch
//   into per-stage freeze/flush controls for the PC, IF/ID/EXE/MEM stage registers.
//   Tracks memory-wait duration (timeout flag) and total stall cycles (perf counter).
// PARAMETERS
//   MAX_WAIT  256  MEM_WAIT cycles before mem_timeout is raised (>=1)
//   CNT_W     32   width of stall_cycles counter
//   WAIT_W    9    width of internal wait counter; must hold MAX_WAIT
// PORTS
//   clk           in   1       system clock, all state on rising edge
//   rst           in   1       synchronous reset, active-low
//   mem_req       in   1       MEM stage holds a load/store (MEM_R_EN | MEM_W_EN)
//   mem_ready     in   1       cache/SRAM completes the MEM-stage access this cycle
//   hazard        in   1       hazard unit: ID instruction must wait (RAW / load-use)
//   branch_taken  in   1       EXE stage resolved a taken branch
//   freeze_pc     out  1       hold PC register
//   freeze_if     out  1       hold IF stage register
//   freeze_id     out  1       hold ID stage register
//   freeze_exe    out  1       hold EXE stage register
//   freeze_mem    out  1       hold MEM stage register
//   flush_if      out  1       clear IF stage register
//   flush_id      out  1       clear ID stage register (bubble)
//   mem_busy      out  1       high while a memory stall is in effect
//   mem_timeout   out  1       sticky: a MEM_WAIT lasted MAX_WAIT cycles
//   stall_cycles  out  CNT_W   saturating count of cycles with any freeze active
// BEHAVIOUR
//   - States: RUN, MEM_WAIT. Reset (rst=0 at edge): state=RUN, wait_cnt=0, mem_timeout=0,
//     stall_cycles=0. While rst=0 all freeze_*/flush_*/mem_busy are forced 0.
//   - Control outputs are combinational from state and inputs (zero-cycle latency); counters,
//     flag and state are registered.
//   - mem_stall = mem_req & ~mem_ready (RUN) or ~mem_ready (MEM_WAIT).
//   - Priority: mem_stall > branch_taken > hazard.
//   - mem_stall: all five freeze_* = 1, flush_* = 0, mem_busy = 1. Flush is suppressed
//     because stage flush overrides freeze; a pending branch/hazard stays in place and is
//     re-evaluated the cycle the stall ends.
//   - branch_taken (no mem_stall): flush_if = flush_id = 1, all freezes 0 (hazard ignored).
//   - hazard (no mem_stall, no branch): freeze_pc = freeze_if = 1, flush_id = 1, others 0.
//   - Otherwise all outputs 0.
//   - RUN -> MEM_WAIT when mem_req & ~mem_ready; wait_cnt <= 1.
//   - MEM_WAIT: mem_ready=1 -> RUN, wait_cnt <= 0; that cycle freezes are 0 so stage
//     registers capture. mem_ready=0 -> stay, wait_cnt increments, saturating at MAX_WAIT.
//   - mem_req & mem_ready in same RUN cycle (cache hit): no stall, stay RUN.
//   - mem_timeout <= 1 when wait_cnt == MAX_WAIT in MEM_WAIT; sticky until reset; FSM keeps
//     waiting (no abort).
//   - stall_cycles += 1 on each cycle where any freeze_* = 1; holds at 2^CNT_W-1.
//   - Reset mid-MEM_WAIT: returns to RUN next edge regardless of mem_ready.
// TESTING
//   - mem_req=1, mem_ready=0 for 3 cycles then 1 -> freezes high 3 cycles, low 4th;
//     state back to RUN; stall_cycles=3.
//   - mem_req=1, mem_ready=1 -> no freeze, stays RUN, stall_cycles unchanged.
//   - hazard=1 one cycle -> freeze_pc=freeze_if=flush_id=1, freeze_exe/mem=0; stall_cycles+1.
//   - branch_taken=1 & hazard=1 -> flush_if=flush_id=1, freeze_pc=0.
//   - branch_taken=1 during 2-cycle mem stall -> no flush while mem_busy; flush_if/id on
//     release cycle.
//   - MAX_WAIT=4, mem_ready=0 held 6 cycles -> mem_timeout rises after 4th wait cycle,
//     stays 1 after mem_ready; rst=0 clears it and returns RUN.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Freeze/flush sequencer for the 5-stage pipeline: arbitrates memory wait, taken branch and
// hazard stalls, and tracks memory-wait timeout plus a saturating stall-cycle counter.
module pipe_stall_ctrl #(
    parameter int unsigned MAX_WAIT = 256,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             hazard,
    input  logic             branch_taken,
    output logic             freeze_pc,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             freeze_exe,
    output logic             freeze_mem,
    output logic             flush_if,
    output logic             flush_id,
    output logic             mem_busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {StRun, StMemWait} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              any_freeze;

    always_comb begin
        freeze_pc  = 1'b0;
        freeze_if  = 1'b0;
        freeze_id  = 1'b0;
        freeze_exe = 1'b0;
        freeze_mem = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        mem_busy   = 1'b0;
        mem_stall  = (state == StRun) ? (mem_req & ~mem_ready) : ~mem_ready;
        if (rst) begin
            // Flush would override freeze, so a pending branch/hazard waits out the mem stall.
            if (mem_stall) begin
                freeze_pc  = 1'b1;
                freeze_if  = 1'b1;
                freeze_id  = 1'b1;
                freeze_exe = 1'b1;
                freeze_mem = 1'b1;
                mem_busy   = 1'b1;
            end else if (branch_taken) begin
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (hazard) begin
                freeze_pc = 1'b1;
                freeze_if = 1'b1;
                flush_id  = 1'b1;
            end
        end
        any_freeze = freeze_pc | freeze_if | freeze_id | freeze_exe | freeze_mem;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= StRun;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            unique case (state)
                StRun: begin
                    if (mem_req && !mem_ready) begin
                        state    <= StMemWait;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                StMemWait: begin
                    if (mem_ready) begin
                        state    <= StRun;
                        wait_cnt <= '0;
                    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= StRun;
            endcase
            // Timeout only flags; the access keeps waiting.
            if (state == StMemWait && wait_cnt == WAIT_W'(MAX_WAIT)) begin
                mem_timeout <= 1'b1;
            end
            if (any_freeze && stall_cycles != {CNT_W{1'b1}}) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule
